// File: rtl/rns_modmul_pipe_pkg.sv
// Shared RNS constants: the concatenated modulus table, precomputed Barrett factors,
// the operation encoding and residue types.
package rns_modmul_pipe_pkg;

    localparam int W            = 32;
    localparam int Q_BASIS_LEN  = 2;
    localparam int B_BASIS_LEN  = 2;
    localparam int BA_BASIS_LEN = 1;
    localparam int NUM_MODULI   = Q_BASIS_LEN + B_BASIS_LEN + BA_BASIS_LEN;
    localparam int IDX_W        = $clog2(NUM_MODULI);
    localparam int N_SLOTS      = 4;
    localparam int LANES_DEF    = 4;
    localparam int TAG_W_DEF    = 8;
    localparam int BEATS_PER_POLY_DEF = N_SLOTS * NUM_MODULI / LANES_DEF;

    typedef logic [W-1:0]   residue_t;
    typedef logic [2*W-1:0] wide_t;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MAC = 2'b11
    } rns_op_t;

    // Index 0 is the rightmost element of each packed basis.
    localparam logic [Q_BASIS_LEN-1:0][W-1:0]  Q_BASIS  = {32'd4294967291, 32'd97};
    localparam logic [B_BASIS_LEN-1:0][W-1:0]  B_BASIS  = {32'd12289, 32'd4294967279};
    localparam logic [BA_BASIS_LEN-1:0][W-1:0] BA_BASIS = {32'd65537};

    localparam logic [NUM_MODULI-1:0][W-1:0] MOD_TABLE = {BA_BASIS, B_BASIS, Q_BASIS};

    function automatic wide_t barrett_mu(input residue_t q);
        logic [2*W:0] num;
        num = {1'b1, {(2*W){1'b0}}};
        return wide_t'(num / {{(W+1){1'b0}}, q});
    endfunction

    function automatic logic [NUM_MODULI-1:0][2*W-1:0] build_mu_table();
        logic [NUM_MODULI-1:0][2*W-1:0] t;
        for (int i = 0; i < NUM_MODULI; i++) begin
            t[i] = barrett_mu(MOD_TABLE[i]);
        end
        return t;
    endfunction

    localparam logic [NUM_MODULI-1:0][2*W-1:0] MU_TABLE = build_mu_table();

endpackage

// File: rtl/rns_barrett_lane.sv
// One residue lane, stages S2..S4: operand combine, Barrett quotient estimate,
// remainder correction and optional MAC accumulate.
module rns_barrett_lane
    import rns_modmul_pipe_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     adv,
    input  rns_op_t  op,
    input  residue_t q,
    input  wide_t    mu,
    input  residue_t a,
    input  residue_t b,
    input  residue_t c,
    input  logic     kill,
    output residue_t res
);

    rns_op_t  op2_r, op3_r;
    residue_t q2_r, q3_r, c2_r, c3_r;
    wide_t    mu2_r, p2_r, p3_r, qhat3_r;
    wide_t    p_s, qhat_s, r0_s, r1_s, r2_s;
    residue_t red_s, fin_s, res_r;
    logic [W:0] sum_s;

    // S2 operand combine; SUB biases by q so the result stays non-negative.
    always_comb begin
        p_s = {(2*W){1'b0}};
        case (op)
            OP_MUL:  p_s = wide_t'(a) * wide_t'(b);
            OP_MAC:  p_s = wide_t'(a) * wide_t'(b);
            OP_ADD:  p_s = wide_t'(a) + wide_t'(b);
            OP_SUB:  p_s = wide_t'(a) + wide_t'(q) - wide_t'(b);
            default: p_s = {(2*W){1'b0}};
        endcase
    end

    // S3 quotient estimate: high half of the 4W-bit product p*mu.
    always_comb begin
        qhat_s = wide_t'(({{(2*W){1'b0}}, p2_r} * {{(2*W){1'b0}}, mu2_r}) >> (2*W));
    end

    // S4 correction: the estimate undershoots by at most two multiples of q.
    always_comb begin
        r0_s  = p3_r - (qhat3_r * wide_t'(q3_r));
        r1_s  = (r0_s >= wide_t'(q3_r)) ? (r0_s - wide_t'(q3_r)) : r0_s;
        r2_s  = (r1_s >= wide_t'(q3_r)) ? (r1_s - wide_t'(q3_r)) : r1_s;
        red_s = residue_t'(r2_s);
        sum_s = {1'b0, red_s} + {1'b0, c3_r};
        if (op3_r == OP_MAC) begin
            fin_s = (sum_s >= {1'b0, q3_r}) ? residue_t'(sum_s - {1'b0, q3_r}) : residue_t'(sum_s);
        end else begin
            fin_s = red_s;
        end
    end

    // Stage registers S2..S4, all gated by the global advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op2_r   <= OP_MUL;
            q2_r    <= {W{1'b0}};
            mu2_r   <= {(2*W){1'b0}};
            c2_r    <= {W{1'b0}};
            p2_r    <= {(2*W){1'b0}};
            op3_r   <= OP_MUL;
            q3_r    <= {W{1'b0}};
            c3_r    <= {W{1'b0}};
            p3_r    <= {(2*W){1'b0}};
            qhat3_r <= {(2*W){1'b0}};
            res_r   <= {W{1'b0}};
        end else if (adv) begin
            op2_r   <= op;
            q2_r    <= q;
            mu2_r   <= mu;
            c2_r    <= c;
            p2_r    <= p_s;
            op3_r   <= op2_r;
            q3_r    <= q2_r;
            c3_r    <= c2_r;
            p3_r    <= p2_r;
            qhat3_r <= qhat_s;
            res_r   <= kill ? {W{1'b0}} : fin_s;
        end
    end

    assign res = res_r;

endmodule

// File: rtl/rns_modmul_pipe.sv
// Streaming multi-lane RNS modular ALU: handshake, stage valids, modulus lookup,
// tag/error sideband and per-polynomial beat counting around LANES Barrett lanes.
module rns_modmul_pipe
    import rns_modmul_pipe_pkg::*;
#(
    parameter int LANES          = LANES_DEF,
    parameter int TAG_W          = TAG_W_DEF,
    parameter int BEATS_PER_POLY = BEATS_PER_POLY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [IDX_W-1:0]   in_mod_idx,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic [LANES*W-1:0] in_c,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_last,
    output logic               out_err
);

    localparam int CNT_W = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_POLY - 1);

    logic               adv_s;
    logic               hit_s, err_s;
    residue_t           q_s;
    wide_t              mu_s;
    logic               v1_r, v2_r, v3_r;
    rns_op_t            op1_r;
    logic [LANES*W-1:0] a1_r, b1_r, c1_r;
    residue_t           q1_r;
    wide_t              mu1_r;
    logic [TAG_W-1:0]   tag1_r, tag2_r, tag3_r;
    logic               err1_r, err2_r, err3_r;
    logic [CNT_W-1:0]   cnt_r;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Modulus lookup as an OR-mux; an index outside the table selects nothing and flags err.
    always_comb begin
        q_s   = {W{1'b0}};
        mu_s  = {(2*W){1'b0}};
        err_s = 1'b1;
        hit_s = 1'b0;
        for (int i = 0; i < NUM_MODULI; i++) begin
            hit_s = (in_mod_idx == IDX_W'(i));
            q_s   = q_s | (MOD_TABLE[i] & {W{hit_s}});
            mu_s  = mu_s | (MU_TABLE[i] & {(2*W){hit_s}});
            err_s = err_s & !hit_s;
        end
    end

    // S1 input capture plus valid/tag/err sideband through S4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            v3_r      <= 1'b0;
            out_valid <= 1'b0;
            op1_r     <= OP_MUL;
            a1_r      <= {(LANES*W){1'b0}};
            b1_r      <= {(LANES*W){1'b0}};
            c1_r      <= {(LANES*W){1'b0}};
            q1_r      <= {W{1'b0}};
            mu1_r     <= {(2*W){1'b0}};
            tag1_r    <= {TAG_W{1'b0}};
            tag2_r    <= {TAG_W{1'b0}};
            tag3_r    <= {TAG_W{1'b0}};
            out_tag   <= {TAG_W{1'b0}};
            err1_r    <= 1'b0;
            err2_r    <= 1'b0;
            err3_r    <= 1'b0;
            out_err   <= 1'b0;
        end else if (adv_s) begin
            v1_r      <= in_valid;
            v2_r      <= v1_r;
            v3_r      <= v2_r;
            out_valid <= v3_r;
            op1_r     <= rns_op_t'(in_op);
            a1_r      <= in_a;
            b1_r      <= in_b;
            c1_r      <= in_c;
            q1_r      <= q_s;
            mu1_r     <= mu_s;
            tag1_r    <= in_tag;
            tag2_r    <= tag1_r;
            tag3_r    <= tag2_r;
            out_tag   <= tag3_r;
            err1_r    <= err_s;
            err2_r    <= err1_r;
            err3_r    <= err2_r;
            out_err   <= err3_r;
        end
    end

    // Output-transfer counter marking the final beat of each polynomial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready) begin
            cnt_r <= (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
        end
    end

    assign out_last = out_valid && (cnt_r == LAST_CNT);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rns_barrett_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv_s),
            .op    (op1_r),
            .q     (q1_r),
            .mu    (mu1_r),
            .a     (a1_r[k*W +: W]),
            .b     (b1_r[k*W +: W]),
            .c     (c1_r[k*W +: W]),
            .kill  (err3_r),
            .res   (out_data[k*W +: W])
        );
    end

endmodule

// File: tb/tb_rns_modmul_pipe.sv
// Scoreboard bench: the driver queues expected beats on accept, a negedge monitor
// pops and compares on every output transfer and checks stall stability.
module tb_rns_modmul_pipe;

    localparam int W = 32;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int BPP = 4;
    localparam logic [31:0] Q1 = 32'd4294967291;
    localparam logic [31:0] Q2 = 32'd4294967279;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_op = 2'b00;
    logic [2:0]         in_mod_idx = 3'd0;
    logic [LANES*W-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    wire                out_ready;
    logic [LANES*W-1:0] out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_last;
    logic               out_err;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   tag;
        logic         err;
        int           acc_cyc;
        logic         lat;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;
    logic rnd_bit = 1'b1;
    logic [31:0] tq [5] = '{32'd97, Q1, Q2, 32'd12289, 32'd65537};

    assign out_ready = (rdy_mode == 0) || ((rdy_mode == 2) && rnd_bit);

    rns_modmul_pipe #(.LANES(LANES), .TAG_W(TAG_W), .BEATS_PER_POLY(BPP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_mod_idx(in_mod_idx), .in_a(in_a), .in_b(in_b),
        .in_c(in_c), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [63:0] q,
                                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        case (op)
            2'b00:   return 32'((a * b) % q);
            2'b01:   return 32'((a + b) % q);
            2'b10:   return 32'((a + q - b) % q);
            default: return 32'((((a * b) % q) + c) % q);
        endcase
    endfunction

    // Monitor: stall stability, scoreboard pop on transfer, last-beat model.
    logic         held_v = 1'b0;
    logic [127:0] held_data;
    logic [7:0]   held_tag;
    logic         held_last, held_err;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            xfer_cnt = 0;
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_tag", out_tag, held_tag);
                check("stall_last", out_last, held_last);
                check("stall_err", out_err, held_err);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                held_v = 1'b1;
                held_data = out_data;
                held_tag = out_tag;
                held_last = out_last;
                held_err = out_err;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_beat: got tag %0h required no beat", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("data", out_data, e.data);
                    check("tag", out_tag, e.tag);
                    check("err", out_err, e.err);
                    check("last", out_last, (xfer_cnt % BPP) == (BPP - 1));
                    if (e.lat) check("latency", cyc - e.acc_cyc, 4);
                    xfer_cnt++;
                end
            end
        end
    end

    // Presents one beat from posedge+1 until accepted; returns at posedge+1 with in_valid still high.
    task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] c, input logic [7:0] tag,
                        input logic [127:0] exp_data, input logic exp_err, input logic lat);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_mod_idx = idx;
        in_a = a;
        in_b = b;
        in_c = c;
        in_tag = tag;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{exp_data, tag, exp_err, cyc, lat});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: tag %0h never accepted", tag);
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op;
        logic [2:0]   idx;
        logic [127:0] a, b, c, ex;
        logic         er;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_err", out_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, all lanes equal, back-to-back, latency checked.
        send(2'b00, 3'd0, rep(96), rep(96), rep(0), 8'h01, rep(1), 1'b0, 1'b1);
        send(2'b01, 3'd0, rep(96), rep(5), rep(0), 8'h02, rep(4), 1'b0, 1'b1);
        send(2'b10, 3'd0, rep(3), rep(5), rep(0), 8'h03, rep(95), 1'b0, 1'b1);
        send(2'b11, 3'd0, rep(10), rep(10), rep(96), 8'h04, rep(2), 1'b0, 1'b1);
        send(2'b00, 3'd1, rep(Q1 - 1), rep(Q1 - 1), rep(0), 8'h05, rep(1), 1'b0, 1'b1);
        send(2'b00, 3'd1, rep(32'h8000_0000), rep(2), rep(0), 8'h06, rep(5), 1'b0, 1'b1);
        send(2'b10, 3'd1, rep(0), rep(Q1 - 1), rep(0), 8'h07, rep(1), 1'b0, 1'b1);
        send(2'b11, 3'd1, rep(Q1 - 1), rep(Q1 - 1), rep(Q1 - 1), 8'h08, rep(0), 1'b0, 1'b1);
        send(2'b01, 3'd1, rep(Q1 - 1), rep(Q1 - 1), rep(0), 8'h09, rep(Q1 - 2), 1'b0, 1'b1);
        send(2'b00, 3'd2, rep(Q2 - 1), rep(Q2 - 1), rep(0), 8'h0a, rep(1), 1'b0, 1'b1);
        send(2'b00, 3'd3, rep(12288), rep(2), rep(0), 8'h0b, rep(12287), 1'b0, 1'b1);
        send(2'b00, 3'd4, rep(256), rep(256), rep(0), 8'h0c, rep(65536), 1'b0, 1'b1);
        send(2'b01, 3'd4, rep(65536), rep(1), rep(0), 8'h0d, rep(0), 1'b0, 1'b1);
        send(2'b00, 3'd5, rep(3), rep(3), rep(0), 8'h0e, rep(0), 1'b1, 1'b1);
        send(2'b00, 3'd0, rep(96), rep(96), rep(0), 8'h0f, rep(1), 1'b0, 1'b1);
        send(2'b01, 3'd7, rep(1), rep(1), rep(0), 8'h10, rep(0), 1'b1, 1'b1);
        send(2'b00, 3'd0, {32'd5, 32'd4, 32'd3, 32'd2}, rep(50), rep(0), 8'h11,
             {32'd56, 32'd6, 32'd53, 32'd3}, 1'b0, 1'b1);
        drain();

        // Backpressure: 10-cycle stall right after the first output.
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    send(2'b00, 3'd0, rep(32'(t + 1)), rep(2), rep(0), 8'(t), rep(32'(2 * t + 2)), 1'b0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 60 && !seen; k++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                check("bp_first_output_seen", seen, 1);
                @(posedge clk);
                #1;
                rdy_mode = 1;
                repeat (10) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        drain();

        // Mid-stream reset with three beats in flight.
        for (int t = 0; t < 3; t++) begin
            send(2'b01, 3'd0, rep(32'(t)), rep(1), rep(0), 8'(8'h40 + t), rep(32'(t + 1)), 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First post-reset beat (latency), then 11 more under random out_ready.
        send(2'b00, 3'd0, rep(20), rep(5), rep(0), 8'h50, rep(3), 1'b0, 1'b1);
        drain();
        rdy_mode = 2;
        for (int t = 1; t < 12; t++) begin
            send(2'b01, 3'd0, rep(32'(t)), rep(90), rep(0), 8'(8'h50 + t), rep(32'((t + 90) % 97)), 1'b0, 1'b0);
        end
        drain();

        // Random in-range beats with distinct lanes, checked against a % model.
        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            idx = 3'($urandom_range(0, 5));
            er = (idx == 3'd5);
            for (int k = 0; k < LANES; k++) begin
                logic [31:0] q, av, bv, cv;
                q = er ? 32'd97 : tq[idx];
                av = $urandom % q;
                bv = $urandom % q;
                cv = $urandom % q;
                a[k*W +: W] = av;
                b[k*W +: W] = bv;
                c[k*W +: W] = cv;
                ex[k*W +: W] = er ? 32'd0 : ref_op(op, {32'd0, q}, {32'd0, av}, {32'd0, bv}, {32'd0, cv});
            end
            send(op, idx, a, b, c, 8'(n), ex, er, 1'b0);
        end
        drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
